// File: rtl/dmem_pkg.sv
// Shared types and helpers for the wait-state data memory.
package dmem_pkg;

  // Access sequencer states; the encoding is also visible on dbg_state.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } dmem_state_t;

  // Width used for the fault comparison so any ADDR_W up to 64 fits.
  localparam int CHK_W = 64;

  // Number of byte-lane bits in a word of data_w bits.
  function automatic int lane_bits(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  // Number of word-index bits for a memory of depth words.
  function automatic int idx_bits(input int depth);
    return $clog2(depth);
  endfunction

  // An access is rejected when the offset is past the last byte (which also
  // covers addresses below the base, since the offset wraps) or when a word
  // access is not aligned to a word boundary.
  function automatic logic dmem_fault(input logic [CHK_W-1:0] off,
                                      input logic [CHK_W-1:0] limit,
                                      input logic [CHK_W-1:0] lane_mask,
                                      input logic             byte_acc);
    return (off >= limit) || (!byte_acc && ((off & lane_mask) != '0));
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage with per-byte write enables, combinational read and
// clear-on-reset.
import dmem_pkg::*;

module dmem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int BPW    = 4,
  parameter int IDX_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BPW-1:0]    we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Byte-lane writes on the clock edge; every word cleared while in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int b = 0; b < BPW; b++) begin
        if (we[b]) mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/dmem_waitstate.sv
// Data memory for the MEM stage with programmable wait states, byte/word
// access and fault reporting for out-of-range or misaligned addresses.
//
// Handshake: the requester raises mem_r_en or mem_w_en and holds it together
// with addr/wdata/byte_acc until ready is seen high; ready is a single-cycle
// completion pulse and fault/rdata are meaningful in that same cycle. Requests
// are only sampled in IDLE, so the pipeline stalls on (r_en|w_en) & ~ready.
import dmem_pkg::*;

module dmem_waitstate #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 64,
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_r_en,
  input  logic              mem_w_en,
  input  logic              byte_acc,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              fault,
  output logic [1:0]        dbg_state
);

  localparam int BPW    = DATA_W / 8;
  localparam int LANE_W = lane_bits(DATA_W);
  localparam int IDX_W  = idx_bits(DEPTH);
  localparam int CNT_W  = $clog2(WAIT_CYCLES + 1);
  localparam logic [CHK_W-1:0] LIMIT     = CHK_W'(DEPTH * BPW);
  localparam logic [CHK_W-1:0] LANE_MASK = CHK_W'(BPW - 1);

  dmem_state_t       state;
  logic [CNT_W-1:0]  cnt;
  logic              op_w;
  logic              byte_q;
  logic              fault_q;
  logic [IDX_W-1:0]  idx_q;
  logic [LANE_W-1:0] lane_q;
  logic [DATA_W-1:0] wdata_q;

  logic [ADDR_W-1:0] off_in;
  logic              fault_in;
  logic              fire;
  logic [BPW-1:0]    we;
  logic [DATA_W-1:0] arr_wdata;
  logic [DATA_W-1:0] arr_rdata;
  logic [7:0]        rd_byte;

  // Address decode of the live request; only used when IDLE samples it.
  always_comb begin
    off_in   = addr - ADDR_W'(BASE_ADDR);
    fault_in = dmem_fault(CHK_W'(off_in), LIMIT, LANE_MASK, byte_acc);
  end

  // Array write strobes for the last BUSY cycle; faulted writes never land.
  always_comb begin
    fire      = (state == BUSY) && (cnt == '0);
    we        = '0;
    arr_wdata = byte_q ? {BPW{wdata_q[7:0]}} : wdata_q;
    if (fire && op_w && !fault_q) begin
      we = byte_q ? (BPW'(1) << lane_q) : {BPW{1'b1}};
    end
    rd_byte = 8'(arr_rdata >> {lane_q, 3'b000});
  end

  dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .BPW    (BPW),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .idx   (idx_q),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

  // Access sequencer: latch in IDLE, count wait states in BUSY, pulse in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      op_w    <= 1'b0;
      byte_q  <= 1'b0;
      fault_q <= 1'b0;
      idx_q   <= '0;
      lane_q  <= '0;
      wdata_q <= '0;
      ready   <= 1'b0;
      fault   <= 1'b0;
      rdata   <= '0;
    end else begin
      ready <= 1'b0;
      fault <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_w_en || mem_r_en) begin
            op_w    <= mem_w_en;
            byte_q  <= byte_acc;
            fault_q <= fault_in;
            idx_q   <= off_in[LANE_W +: IDX_W];
            lane_q  <= off_in[LANE_W-1:0];
            wdata_q <= wdata;
            cnt     <= CNT_W'(WAIT_CYCLES - 1);
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            state <= DONE;
            ready <= 1'b1;
            fault <= fault_q;
            if (fault_q) begin
              rdata <= '0;
            end else if (!op_w) begin
              rdata <= byte_q ? DATA_W'(rd_byte) : arr_rdata;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: doc/dmem_waitstate.md
# dmem_waitstate

Parametrised data memory for the ARM pipeline MEM stage. It adds byte and word access, a configurable base address and depth, a programmable wait-state latency with a ready handshake that stalls the pipeline, and fault reporting for out-of-range or misaligned accesses. It is a drop-in next generation of the single-cycle data memory: the hazard unit freezes the pipeline while a request is pending and `ready` is low.

## Interface
- `DATA_W`, 32: word width; multiple of 8; bytes per word `BPW = DATA_W/8`, a power of two.
- `ADDR_W`, 32: byte-address width.
- `DEPTH`, 64: number of words; power of two.
- `BASE_ADDR`, 1024: byte address of word 0.
- `WAIT_CYCLES`, 2: busy cycles per access; at least 1.

- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `mem_r_en` in 1: read request; held by the requester until `ready`.
- `mem_w_en` in 1: write request; held until `ready`; has priority over `mem_r_en`.
- `byte_acc` in 1: 1 selects a byte access (LDRB/STRB), 0 a word access.
- `addr` in ADDR_W: byte address (the ALU result).
- `wdata` in DATA_W: store data (Val_Rm); byte stores use `wdata[7:0]`.
- `rdata` out DATA_W: load data; byte loads are zero-extended.
- `ready` out 1: one-cycle pulse marking access completion.
- `fault` out 1: valid with `ready`; 1 means the access was rejected.

## Operation
- Offset: `off = addr - BASE_ADDR`, computed modulo 2^ADDR_W.
- Word index: `off >> log2(BPW)`. Byte lane: `off[log2(BPW)-1:0]`.
- Fault conditions:
  - `off >= DEPTH*BPW` (unsigned); this also catches addresses below the base.
  - A word access with a nonzero lane.
- On fault:
  - No memory update.
  - `rdata` is 0.
  - Latency is the same as a normal access.
- FSM states are IDLE, BUSY and DONE.
- IDLE:
  - If `mem_w_en | mem_r_en`, latch `addr`, `wdata`, `byte_acc`, the op (write wins) and the fault flag.
  - Load the counter with WAIT_CYCLES-1 and go to BUSY.
- BUSY:
  - Decrement the counter.
  - When it is 0, perform the access and go to DONE.
  - Word write: full word. Byte write: only the selected lane; the other lanes are kept.
- DONE:
  - Assert `ready` for one cycle, and `fault` if latched.
  - `rdata` is updated here for reads and holds its value until the next read completes.
  - Then go to IDLE.
- Writes leave `rdata` unchanged.
- Requests are sampled only in IDLE. Input changes during BUSY or DONE are ignored; the latched values are used.
- Back-to-back accesses therefore have one IDLE cycle between the DONE of one and the sampling of the next.

## Timing
- Request seen in IDLE at cycle 0 leads to BUSY in cycles 1..WAIT_CYCLES, then DONE with `ready=1` at cycle WAIT_CYCLES+1.
- The write takes effect at the edge entering DONE.
- Reset values:
  - State is IDLE.
  - `ready`, `fault` and `rdata` are 0.
  - Counter is 0.
  - All DEPTH words are cleared to 0.
- Reset mid-access aborts it. No write is performed, `ready` is not pulsed, and the state returns to IDLE.
- Requester obligation: hold the request and its inputs until `ready`. The stall equation for the hazard unit is `(mem_r_en|mem_w_en) & ~ready`.

## Structure
- Package `dmem_pkg` holds:
  - the state enum `dmem_state_t` (IDLE, BUSY, DONE);
  - the constants for the lane-bit count and index width, derived with `$clog2`;
  - a function that performs the fault check.
- Sub-module `dmem_array`: DEPTH×DATA_W storage with:
  - synchronous write plus a per-byte write enable of BPW bits;
  - asynchronous read;
  - clear on reset.
- The top level holds the FSM, the counter, the input latches and the address decode.

## Test plan
- Reset, then a word write of 0xDEADBEEF to address 1024, then a word read of 1024: `rdata=0xDEADBEEF`, `fault=0`, `ready` arrives 3 cycles after the request (WAIT_CYCLES=2).
- Word 0x11223344 at 1028, then a byte write of 0xAA to 1029, then a word read of 1028: 0x1122AA44. A byte read of 1031 returns 0x00000011.
- Word read of 1030 (misaligned), a read of 1020 (below base), and a write to 1024+256 (past the end): each gives `fault=1`, `rdata=0`, no memory change, and the normal latency.
- `mem_w_en` and `mem_r_en` both high: a write is performed. Changing `addr` during BUSY has no effect on the access.
- Assert `rst` in the first BUSY cycle of a write to 1032: no `ready` pulse, and a later read of 1032 returns 0.
- Two consecutive held requests: the second `ready` comes WAIT_CYCLES+2 cycles after the first `ready`.
